tiny_io_driver: RTL
===================

TINY_IO_DRIVER -- requirements
Module: tiny_io_driver

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4: cycles user_in is held stable before the strobe edge; legal range 1..255.
REQ-002 Parameter HOLD_CYCLES, default 4: cycles the strobe (user_in[0]) is held high; legal range 1..255.
REQ-003 wb_clk_i  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  driver can accept a command.
REQ-007 cmd_data  input  8  word to apply to the user design inputs.
REQ-008 cmd_pulse  input  1  1 = generate a strobe pulse on bit 0; 0 = drive cmd_data[0] statically.
REQ-009 user_in  output  8  drives the user design's 8 input pins.
REQ-010 user_out  input  8  the user design's 8 output pins, asynchronous to wb_clk_i.
REQ-011 rsp_valid  output  1  sampled response available.
REQ-012 rsp_ready  input  1  consumer accepts the response.
REQ-013 rsp_data  output  8  captured user_out value.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 FSM states: IDLE, SETUP, HIGH, SAMPLE, RESP; one 8-bit down-counter shared by SETUP, HIGH and SAMPLE.
REQ-016 cmd_ready SHALL equal (state == IDLE); a command is accepted on an edge where cmd_valid && cmd_ready.
REQ-017 On accept: user_in <= {cmd_data[7:1], cmd_pulse ? 0 : cmd_data[0]}; pulse flag latched; go to SETUP; counter <= SETTLE_CYCLES-1.
REQ-018 SETUP lasts exactly SETTLE_CYCLES cycles; on exit, user_in[0] <= 1 if pulse flag set; go to HIGH; counter <= HOLD_CYCLES-1.
REQ-019 HIGH lasts exactly HOLD_CYCLES cycles; on exit go to SAMPLE (counter <= 1) when TINY_IO_SYNC_EN is defined, else perform capture directly (REQ-020).
REQ-020 Capture edge: rsp_data <= sampled user_out; rsp_valid <= 1; user_in[0] <= 0 if pulse flag set; go to RESP.
REQ-021 Accept-to-rsp_valid latency: SETTLE_CYCLES+HOLD_CYCLES+2 cycles with sync (10 at defaults), SETTLE_CYCLES+HOLD_CYCLES without (8).
REQ-022 user_in[7:1] SHALL remain constant from the accept edge until the next accepted command.
REQ-023 RESP: rsp_valid, rsp_data held stable until rsp_valid && rsp_ready; on that edge rsp_valid <= 0, go to IDLE; cmd_ready rises one cycle later (no same-cycle accept).
REQ-024 Backpressure: rsp_ready low indefinitely SHALL stall in RESP with cmd_ready low; commands offered meanwhile are not accepted or lost.
REQ-025 cmd_valid in non-IDLE states SHALL be ignored; cmd_data, cmd_pulse sampled only at accept.

Reset
REQ-026 rst_n low SHALL immediately (asynchronously) force state IDLE, counter 0, user_in 8'h00, rsp_data 8'h00, rsp_valid 0, busy 0, cmd_ready 1 after release, synchronizer flops 0.
REQ-027 Reset mid-operation SHALL abandon the transaction with no response emitted; first command after release behaves as from power-up.

Configuration
REQ-028 Macro TINY_IO_SYNC_EN defined: user_out passes through a 2-flop synchronizer; capture uses the second flop; SAMPLE state occupies 2 cycles.
REQ-029 TINY_IO_SYNC_EN undefined: no synchronizer, user_out captured directly at HIGH exit; SAMPLE state unreachable.

Verification
REQ-030 Defaults, sync on; cmd 8'hA5, pulse=1; user model outputs ~input latched on strobe rise -> user_in 8'hA4 for 4 cycles, 8'hA5 for 4, rsp_data 8'h5A, rsp_valid 10 cycles after accept.
REQ-031 cmd 8'h3C, pulse=0; user_out tied 8'h81 -> user_in[0] stays 0 throughout, rsp_data 8'h81.
REQ-032 rsp_ready held low 20 cycles, cmd_valid high with 8'hFF -> cmd_ready low, user_in unchanged, single response; accept of 8'hFF exactly 1 cycle after handshake.
REQ-033 rst_n pulsed low during HIGH -> user_in 8'h00 and rsp_valid 0 same cycle; no response after release.
REQ-034 SETTLE_CYCLES=1, HOLD_CYCLES=1, sync off -> rsp_valid 2 cycles after accept; sync on -> 4 cycles.

Source files
------------

// File: rtl/tiny_io_driver.sv
// Command-driven stimulus/capture driver for an 8-pin user design.
// Define TINY_IO_SYNC_EN to add a 2-flop synchronizer on user_out.
module tiny_io_driver #(
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter int unsigned HOLD_CYCLES   = 4
) (
   input  logic       wb_clk_i,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [7:0] cmd_data,
   input  logic       cmd_pulse,
   output logic [7:0] user_in,
   input  logic [7:0] user_out,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_data,
   output logic       busy
);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      HIGH,
      SAMPLE,
      RESP
   } state_e;

   localparam logic [7:0] SETTLE_M1 = 8'(SETTLE_CYCLES - 1);
   localparam logic [7:0] HOLD_M1   = 8'(HOLD_CYCLES - 1);

   state_e     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] uin_q, uin_d;
   logic [7:0] rsp_q, rsp_d;
   logic       rvld_q, rvld_d;
   logic       pulse_q, pulse_d;
   logic       cap;
   logic [7:0] samp;

`ifdef TINY_IO_SYNC_EN
   logic [7:0] sync1_q, sync2_q;

   always_ff @(posedge wb_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 8'h00;
         sync2_q <= 8'h00;
      end else begin
         sync1_q <= user_out;
         sync2_q <= sync1_q;
      end
   end

   assign samp = sync2_q;
`else
   assign samp = user_out;
`endif

   always_ff @(posedge wb_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 8'h00;
         uin_q   <= 8'h00;
         rsp_q   <= 8'h00;
         rvld_q  <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         uin_q   <= uin_d;
         rsp_q   <= rsp_d;
         rvld_q  <= rvld_d;
         pulse_q <= pulse_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      uin_d   = uin_q;
      rsp_d   = rsp_q;
      rvld_d  = rvld_q;
      pulse_d = pulse_q;
      cap     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               uin_d   = {cmd_data[7:1],
                          cmd_pulse ? 1'b0 : cmd_data[0]};
               pulse_d = cmd_pulse;
               cnt_d   = SETTLE_M1;
               state_d = SETUP;
            end
         end
         SETUP: begin
            if (cnt_q == 8'h00) begin
               if (pulse_q) uin_d[0] = 1'b1;
               cnt_d   = HOLD_M1;
               state_d = HIGH;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         HIGH: begin
            if (cnt_q == 8'h00) begin
`ifdef TINY_IO_SYNC_EN
               cnt_d   = 8'd1;
               state_d = SAMPLE;
`else
               cap = 1'b1;
`endif
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         SAMPLE: begin
            if (cnt_q == 8'h00) cap = 1'b1;
            else cnt_d = cnt_q - 8'd1;
         end
         RESP: begin
            if (rsp_ready) begin
               rvld_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // Capture also ends the strobe so the user sees a clean falling edge.
      if (cap) begin
         rsp_d   = samp;
         rvld_d  = 1'b1;
         if (pulse_q) uin_d[0] = 1'b0;
         state_d = RESP;
      end
   end

   assign cmd_ready = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign user_in   = uin_q;
   assign rsp_valid = rvld_q;
   assign rsp_data  = rsp_q;

endmodule
